// File: rtl/pc_sequencer_if.sv
// Command handshake and PC datapath strobe bundle for pc_sequencer.
// The sequencer side uses the slave modport; the command source or datapath side uses master.
interface pc_sequencer_if;
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic              cmd_ready;
  logic [7:0]        adl_in;
  logic [7:0]        adh_in;
  logic signed [7:0] offset;
  logic              pcl_load;
  logic              adl_load;
  logic [7:0]        pcl_data;
  logic [7:0]        adl_data;
  logic              pch_load;
  logic [7:0]        pch_data;
  logic [15:0]       pc;
  logic              done;
  logic              page_cross;

  modport master (
    output cmd_valid, cmd, adl_in, adh_in, offset,
    input  cmd_ready, pcl_load, adl_load, pcl_data, adl_data,
           pch_load, pch_data, pc, done, page_cross
  );

  modport slave (
    input  cmd_valid, cmd, adl_in, adh_in, offset,
    output cmd_ready, pcl_load, adl_load, pcl_data, adl_data,
           pch_load, pch_data, pc, done, page_cross
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: runs INC / JUMP / BRANCH (and VECTOR when the
// PCS_VECTOR_EN macro is defined) as one- or two-cycle strobe sequences.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
`ifdef PCS_VECTOR_EN
  , parameter logic [15:0] VECTOR = 16'hFFFC
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIX} state_t;
  typedef enum logic [1:0] {CMD_INC, CMD_JUMP, CMD_BRANCH, CMD_VECTOR} cmd_t;

  state_t            state, state_nxt;
  logic [15:0]       pc;
  cmd_t              op_q;
  logic [7:0]        adl_q;
  logic [7:0]        adh_q;
  logic signed [7:0] off_q;

  logic       pcl_load, adl_load, pch_load, done, page_cross;
  logic [7:0] pcl_data, adl_data, pch_data;
  logic [8:0] br_sum;
  logic       br_cross;
  logic       accept;

  function automatic logic [8:0] add_byte(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [7:0] step_page(input logic [7:0] page, input logic down);
    return down ? page - 8'd1 : page + 8'd1;
  endfunction

  assign accept   = bus.cmd_valid && (state == IDLE);
  assign br_sum   = add_byte(pc[7:0], $unsigned(off_q));
  // A carry out of a forward offset, or no carry on a negative one, leaves the page.
  assign br_cross = br_sum[8] ^ off_q[7];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      if (pcl_load) pc[7:0]  <= pcl_data;
      if (adl_load) pc[7:0]  <= adl_data;
      if (pch_load) pc[15:8] <= pch_data;
    end
  end

  // Operands are held for the whole command so the source may move on after accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= cmd_t'(bus.cmd);
      adl_q <= bus.adl_in;
      adh_q <= bus.adh_in;
      off_q <= bus.offset;
    end
  end

  always_comb begin
    state_nxt  = state;
    pcl_load   = 1'b0;
    adl_load   = 1'b0;
    pch_load   = 1'b0;
    pcl_data   = 8'h00;
    adl_data   = 8'h00;
    pch_data   = 8'h00;
    done       = 1'b0;
    page_cross = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) state_nxt = LOW;
      LOW: begin
        case (op_q)
          CMD_INC: begin
            pcl_load = 1'b1;
            pcl_data = pc[7:0] + 8'd1;
            if (pc[7:0] == 8'hFF) begin
              state_nxt = HIGH;
            end else begin
              done      = 1'b1;
              state_nxt = IDLE;
            end
          end
          CMD_JUMP: begin
            adl_load  = 1'b1;
            adl_data  = adl_q;
            state_nxt = HIGH;
          end
          CMD_BRANCH: begin
            pcl_load = 1'b1;
            pcl_data = br_sum[7:0];
            if (br_cross) begin
              state_nxt = FIX;
            end else begin
              done      = 1'b1;
              state_nxt = IDLE;
            end
          end
          CMD_VECTOR: begin
`ifdef PCS_VECTOR_EN
            adl_load  = 1'b1;
            adl_data  = VECTOR[7:0];
            state_nxt = HIGH;
`else
            done      = 1'b1;
            state_nxt = IDLE;
`endif
          end
          default: state_nxt = IDLE;
        endcase
      end
      HIGH: begin
        pch_load  = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
        case (op_q)
          CMD_INC:    pch_data = step_page(pc[15:8], 1'b0);
`ifdef PCS_VECTOR_EN
          CMD_VECTOR: pch_data = VECTOR[15:8];
`endif
          default:    pch_data = adh_q;
        endcase
      end
      FIX: begin
        pch_load   = 1'b1;
        pch_data   = step_page(pc[15:8], off_q[7]);
        page_cross = 1'b1;
        done       = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.pcl_load   = pcl_load;
  assign bus.adl_load   = adl_load;
  assign bus.pcl_data   = pcl_data;
  assign bus.adl_data   = adl_data;
  assign bus.pch_load   = pch_load;
  assign bus.pch_data   = pch_data;
  assign bus.pc         = pc;
  assign bus.done       = done;
  assign bus.page_cross = page_cross;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written reset/handshake sequences.
module tb_pc_sequencer;
  localparam logic [15:0] RST_PC = 16'h8000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic [15:0] start_pc;
    logic [1:0]  cmd;
    logic [7:0]  adl, adh, off;
    int          cyc;
    logic [2:0]  st0;
    logic [7:0]  d0;
    logic [2:0]  st1;
    logic [7:0]  d1;
    logic        xc;
    logic [15:0] end_pc;
  } vec_t;

  vec_t vecs[$];

  // Trace of one command: strobes {pcl,adl,pch} and the strobed data byte per cycle.
  logic [2:0]  tr_st [2];
  logic [7:0]  tr_d  [2];
  logic [1:0]  tr_x;
  logic        tr_rdy_busy;
  int          tr_n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [15:0] sp, input logic [1:0] c,
                     input logic [7:0] a, input logic [7:0] h, input logic [7:0] o,
                     input int cy, input logic [2:0] s0, input logic [7:0] d0,
                     input logic [2:0] s1, input logic [7:0] d1, input logic xc,
                     input logic [15:0] ep);
    vec_t v;
    v.nm = nm; v.start_pc = sp; v.cmd = c; v.adl = a; v.adh = h; v.off = o;
    v.cyc = cy; v.st0 = s0; v.d0 = d0; v.st1 = s1; v.d1 = d1; v.xc = xc; v.end_pc = ep;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] strobed_data();
    if (bus.pcl_load) return bus.pcl_data;
    if (bus.adl_load) return bus.adl_data;
    if (bus.pch_load) return bus.pch_data;
    return 8'h00;
  endfunction

  // Entered and left #1 after a rising edge with the sequencer idle.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] a, input logic [7:0] h,
                         input logic [7:0] o);
    logic seen;
    int   i;
    tr_st[0] = '0; tr_st[1] = '0; tr_d[0] = '0; tr_d[1] = '0;
    tr_x = '0; tr_rdy_busy = 1'b0; tr_n = 0;
    bus.cmd_valid = 1'b1; bus.cmd = c; bus.adl_in = a; bus.adh_in = h; bus.offset = o;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd = ~c; bus.adl_in = 8'h5A; bus.adh_in = 8'hA5; bus.offset = 8'h33;
    seen = 1'b0;
    i = 0;
    while (!seen && i < 4) begin
      if (i < 2) begin
        tr_st[i] = {bus.pcl_load, bus.adl_load, bus.pch_load};
        tr_d[i]  = strobed_data();
        tr_x[i]  = bus.page_cross;
      end
      if (bus.cmd_ready) tr_rdy_busy = 1'b1;
      if (bus.done) begin
        seen = 1'b1;
        tr_n = i + 1;
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic set_pc(input logic [15:0] p);
    run_cmd(2'b01, p[7:0], p[15:8], 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd = 2'b00;
    bus.adl_in = 8'h00; bus.adh_in = 8'h00; bus.offset = 8'h00;

    add("inc_12AA", 16'h12AA, 2'b00, 8'h00, 8'h00, 8'h00, 1, 3'b100, 8'hAB, 3'b000, 8'h00, 1'b0, 16'h12AB);
    add("inc_12FF", 16'h12FF, 2'b00, 8'h00, 8'h00, 8'h00, 2, 3'b100, 8'h00, 3'b001, 8'h13, 1'b0, 16'h1300);
    add("inc_FFFF", 16'hFFFF, 2'b00, 8'h00, 8'h00, 8'h00, 2, 3'b100, 8'h00, 3'b001, 8'h00, 1'b0, 16'h0000);
    add("jump_C0AA", 16'h0000, 2'b01, 8'hAA, 8'hC0, 8'h00, 2, 3'b010, 8'hAA, 3'b001, 8'hC0, 1'b0, 16'hC0AA);
    add("br_fwd_cross", 16'h10F0, 2'b10, 8'h00, 8'h00, 8'h20, 2, 3'b100, 8'h10, 3'b001, 8'h11, 1'b1, 16'h1110);
    add("br_back_cross", 16'h1005, 2'b10, 8'h00, 8'h00, 8'hF0, 2, 3'b100, 8'hF5, 3'b001, 8'h0F, 1'b1, 16'h0FF5);
    add("br_no_cross", 16'h1005, 2'b10, 8'h00, 8'h00, 8'h10, 1, 3'b100, 8'h15, 3'b000, 8'h00, 1'b0, 16'h1015);
    add("br_m128_same", 16'h0080, 2'b10, 8'h00, 8'h00, 8'h80, 1, 3'b100, 8'h00, 3'b000, 8'h00, 1'b0, 16'h0000);
    add("br_back_wrap", 16'h0005, 2'b10, 8'h00, 8'h00, 8'hF0, 2, 3'b100, 8'hF5, 3'b001, 8'hFF, 1'b1, 16'hFFF5);
`ifdef PCS_VECTOR_EN
    add("vector", 16'h1234, 2'b11, 8'h00, 8'h00, 8'h00, 2, 3'b010, 8'hFC, 3'b001, 8'hFF, 1'b0, 16'hFFFC);
`else
    add("vector_off", 16'h1234, 2'b11, 8'h00, 8'h00, 8'h00, 1, 3'b000, 8'h00, 3'b000, 8'h00, 1'b0, 16'h1234);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_pc", bus.pc, RST_PC);
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      check("idle_pc", bus.pc, RST_PC);
      check("idle_ctl", {bus.cmd_ready, bus.pcl_load, bus.adl_load, bus.pch_load, bus.done, bus.page_cross}, 6'b100000);
      check("idle_data", {bus.pcl_data, bus.adl_data, bus.pch_data}, 24'h0);
      @(posedge clk); #1;
    end

    foreach (vecs[k]) begin
      set_pc(vecs[k].start_pc);
      check({vecs[k].nm, "_start"}, bus.pc, vecs[k].start_pc);
      run_cmd(vecs[k].cmd, vecs[k].adl, vecs[k].adh, vecs[k].off);
      check({vecs[k].nm, "_cycles"}, tr_n, vecs[k].cyc);
      check({vecs[k].nm, "_st0"}, {tr_st[0], tr_d[0]}, {vecs[k].st0, vecs[k].d0});
      check({vecs[k].nm, "_st1"}, {tr_st[1], tr_d[1]}, {vecs[k].st1, vecs[k].d1});
      check({vecs[k].nm, "_xcross"}, tr_x, vecs[k].xc ? 2'b10 : 2'b00);
      check({vecs[k].nm, "_busy_rdy"}, tr_rdy_busy, 1'b0);
      check({vecs[k].nm, "_end_pc"}, bus.pc, vecs[k].end_pc);
      check({vecs[k].nm, "_end_rdy"}, bus.cmd_ready, 1'b1);
    end

    // Valid held through a busy JUMP must not queue the INC presented meanwhile.
    set_pc(16'h2000);
    bus.cmd_valid = 1'b1; bus.cmd = 2'b01; bus.adl_in = 8'h34; bus.adh_in = 8'h56;
    @(posedge clk); #1;
    bus.cmd = 2'b00;
    check("busy_low_rdy", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    check("busy_high", {bus.pch_load, bus.done, bus.pch_data}, {2'b11, 8'h56});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("busy_after_pc", bus.pc, 16'h5634);
    check("busy_after_rdy", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    check("busy_no_queue", {bus.pcl_load, bus.adl_load, bus.pch_load, bus.pc}, {3'b000, 16'h5634});

    // Back-to-back INC: the DONE cycle is not ready, the next accept lands one cycle later.
    set_pc(16'h12AA);
    bus.cmd_valid = 1'b1; bus.cmd = 2'b00;
    @(posedge clk); #1;
    check("b2b_first", {bus.done, bus.cmd_ready, bus.pcl_data}, {2'b10, 8'hAB});
    @(posedge clk); #1;
    check("b2b_gap", {bus.cmd_ready, bus.pcl_load, bus.pc}, {2'b10, 16'h12AB});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("b2b_second", {bus.done, bus.pcl_load, bus.pcl_data}, {2'b11, 8'hAC});
    @(posedge clk); #1;
    check("b2b_end_pc", bus.pc, 16'h12AC);

    // Reset during the HIGH cycle of a JUMP discards the partial update.
    set_pc(16'h1111);
    bus.cmd_valid = 1'b1; bus.cmd = 2'b01; bus.adl_in = 8'hAA; bus.adh_in = 8'hC0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("rstmid_low", {bus.adl_load, bus.adl_data}, {1'b1, 8'hAA});
    @(posedge clk); #1;
    check("rstmid_high", bus.pch_load, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstmid_pc", bus.pc, RST_PC);
    check("rstmid_strobes", {bus.pcl_load, bus.adl_load, bus.pch_load, bus.done, bus.page_cross}, 5'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_after", {bus.cmd_ready, bus.pch_load, bus.pc}, {2'b10, RST_PC});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
